// File: rtl/uart_rx_r0_if.sv
// Receiver-side bundle for uart_rx_r0: serial line in, received word and status out.
// Ports: dataIn (serial line), dataOut (last good word), valid / frameErr (1-cycle pulses), busy.
// master = the receiver, slave = whoever drives the line and consumes the word.
interface uart_rx_r0_if #(
  parameter int BIT_WIDTH = 8
);
  logic                 dataIn;
  logic [BIT_WIDTH-1:0] dataOut;
  logic                 valid;
  logic                 frameErr;
  logic                 busy;

  modport master (
    input  dataIn,
    output dataOut,
    output valid,
    output frameErr,
    output busy
  );

  modport slave (
    output dataIn,
    input  dataOut,
    input  valid,
    input  frameErr,
    input  busy
  );
endinterface

// File: rtl/uart_rx_r0.sv
// UART receiver: 2-flop synchronizer, start-bit qualification, MSB-first data, stop check.
// Latency: valid/frameErr 2 + HALF + (BIT_WIDTH+1)*CLKS_PER_BIT edges after the start bit is first captured.
// Backpressure: none; the line cannot be stalled, each word is presented once with a valid pulse.
// Ports: clk, rst (async active-low), bus (master modport: dataIn in; dataOut, valid, frameErr, busy out).
module uart_rx_r0 #(
  parameter int BIT_WIDTH    = 8,
  parameter bit START_BIT    = 1'b0,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic          clk,
  input  logic          rst,
  uart_rx_r0_if.master  bus
);

  localparam int HALF = (CLKS_PER_BIT - 1) / 2;
  localparam int CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW   = $clog2(BIT_WIDTH);

  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  // Only reached when HALF > 0; START is skipped entirely otherwise.
  localparam logic [CW-1:0] HALF_LAST = (HALF > 0) ? CW'(HALF - 1) : '0;
  localparam logic [BW-1:0] BIT_LAST  = BW'(BIT_WIDTH - 1);
  localparam logic          STOP_LVL  = ~START_BIT;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t               r_state, w_state;
  logic [CW-1:0]        r_baud, w_baud;
  logic [BW-1:0]        r_bitc, w_bitc;
  logic [BIT_WIDTH-1:0] r_shift, w_shift;
  logic [BIT_WIDTH-1:0] r_data, w_data;
  logic                 r_valid, w_valid;
  logic                 r_ferr, w_ferr;
  logic                 r_busy, w_busy;
  logic                 r_sync1, r_rxs;

  // Synchronizer resets to the idle level so a reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= STOP_LVL;
      r_rxs   <= STOP_LVL;
    end else begin
      r_sync1 <= bus.dataIn;
      r_rxs   <= r_sync1;
    end
  end

  always_comb begin
    w_state = r_state;
    w_baud  = r_baud;
    w_bitc  = r_bitc;
    w_shift = r_shift;
    w_data  = r_data;
    w_valid = 1'b0;
    w_ferr  = 1'b0;

    case (r_state)
      IDLE: begin
        if (r_rxs == START_BIT) begin
          w_baud = '0;
          w_bitc = '0;
          // With HALF == 0 the detection sample itself is the start-bit check.
          w_state = (HALF > 0) ? START : DATA;
        end
      end

      START: begin
        if (r_baud == HALF_LAST) begin
          w_baud  = '0;
          w_bitc  = '0;
          // A line that is no longer at the start level was a glitch: drop silently.
          w_state = (r_rxs == START_BIT) ? DATA : IDLE;
        end else begin
          w_baud = r_baud + 1'b1;
        end
      end

      DATA: begin
        if (r_baud == BAUD_LAST) begin
          w_baud  = '0;
          // Left shift: first received bit ends up in the MSB.
          w_shift = {r_shift[BIT_WIDTH-2:0], r_rxs};
          if (r_bitc == BIT_LAST) begin
            w_bitc  = '0;
            w_state = STOP;
          end else begin
            w_bitc = r_bitc + 1'b1;
          end
        end else begin
          w_baud = r_baud + 1'b1;
        end
      end

      STOP: begin
        if (r_baud == BAUD_LAST) begin
          w_baud = '0;
          w_bitc = '0;
          if (r_rxs == STOP_LVL) begin
            w_data  = r_shift;
            w_valid = 1'b1;
            w_state = IDLE;
          end else begin
            w_ferr  = 1'b1;
            w_state = BREAK;
          end
        end else begin
          w_baud = r_baud + 1'b1;
        end
      end

      BREAK: begin
        // Wait out a held-low line so it is not mistaken for a new start bit.
        if (r_rxs == STOP_LVL) begin
          w_baud  = '0;
          w_bitc  = '0;
          w_state = IDLE;
        end
      end

      default: begin
        w_baud  = '0;
        w_bitc  = '0;
        w_state = IDLE;
      end
    endcase

    w_busy = (w_state != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_bitc  <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_baud  <= w_baud;
      r_bitc  <= w_bitc;
      r_shift <= w_shift;
      r_data  <= w_data;
      r_valid <= w_valid;
      r_ferr  <= w_ferr;
      r_busy  <= w_busy;
    end
  end

  assign bus.dataOut  = r_data;
  assign bus.valid    = r_valid;
  assign bus.frameErr = r_ferr;
  assign bus.busy     = r_busy;

endmodule

// File: doc/uart_rx_r0.md
UART_RX_R0 -- requirements
Module: uart_rx_r0

Interface
REQ-001 The block SHALL have parameter BIT_WIDTH, default 8, data bits per frame, legal 5..16.
REQ-002 The block SHALL have parameter START_BIT, default 0, start-bit line level; stop and idle level is ~START_BIT.
REQ-003 The block SHALL have parameter CLKS_PER_BIT, default 1, clocks per bit time, legal >= 1; HALF = (CLKS_PER_BIT-1)/2, integer division.
REQ-004 The block SHALL have port clk, input, 1, the one clock; all logic on its rising edge.
REQ-005 The block SHALL have port rst, input, 1, reset; asynchronous, active-low.
REQ-006 The block SHALL have port dataIn, input, 1, serial line, asynchronous to clk.
REQ-007 The block SHALL have port dataOut, output, BIT_WIDTH, last correctly framed received word.
REQ-008 The block SHALL have port valid, output, 1, one-cycle pulse: new word on dataOut.
REQ-009 The block SHALL have port frameErr, output, 1, one-cycle pulse: stop bit sampled wrong.
REQ-010 The block SHALL have port busy, output, 1, high whenever the FSM is not IDLE.

Function
REQ-011 dataIn SHALL pass through a 2-flop synchronizer; the FSM sees only the second-flop output (rxs).
REQ-012 The FSM SHALL have states IDLE, START, DATA, STOP, BREAK; all outputs registered.
REQ-013 In IDLE, the edge on which rxs == START_BIT is observed is the detection edge: go to START if HALF > 0, else straight to DATA (detection sample counts as the start check).
REQ-014 In START, at HALF edges after detection, re-sample rxs: == START_BIT -> DATA; otherwise, as a glitch -> IDLE, with no pulse.
REQ-015 In DATA, sample rxs every CLKS_PER_BIT edges, the first at detection + HALF + CLKS_PER_BIT; shift samples in left so the first data bit lands in dataOut MSB position (MSB-first, matching uart_tx_r0).
REQ-016 After BIT_WIDTH data samples, go to STOP; sample the stop bit CLKS_PER_BIT edges after the last data sample.
REQ-017 Stop == ~START_BIT: on that edge load dataOut with the shifted word, pulse valid for 1 cycle, go to IDLE.
REQ-018 Stop == START_BIT: dataOut unchanged, pulse frameErr for 1 cycle, go to BREAK.
REQ-019 BREAK SHALL hold until rxs == ~START_BIT, then go to IDLE; no detection while in BREAK.
REQ-020 Latency SHALL be fixed: valid/frameErr asserts 2 + HALF + (BIT_WIDTH+1)*CLKS_PER_BIT edges after the edge at which the first sync flop captures the start bit.
REQ-021 IDLE SHALL accept a new start bit on the edge immediately after returning from STOP (back-to-back frames with 1 idle bit).
REQ-022 valid and frameErr SHALL never be high in the same cycle; dataOut SHALL hold until the next valid.
REQ-023 The bit counter SHALL count 0..BIT_WIDTH-1 and the baud counter 0..CLKS_PER_BIT-1 with no wrap beyond range; both clear on every state entry.

Reset
REQ-024 While rst is low: state IDLE, counters 0, shift register 0, dataOut 0, valid 0, frameErr 0, busy 0, sync flops ~START_BIT.
REQ-025 Reset asserted mid-frame SHALL abort immediately; no valid or frameErr pulse may follow deassertion.
REQ-026 After rst deasserts, the first detection SHALL be possible 2 edges later if the line is at START_BIT.

Verification
REQ-027 CLKS_PER_BIT=1, line 0,1,0,1,0,0,1,0,1,1 (0xA5, MSB first) then idle 1 -> dataOut=0xA5, valid high exactly 11 edges after first sync capture, busy high 9 cycles.
REQ-028 Loopback from uart_tx_r0, BIT_WIDTH=8: send 0x00, 0xFF, 0x3C back-to-back -> three valid pulses, words in order, frameErr never high.
REQ-029 Stop bit forced 0 on 0x5A, line then held 0 for 20 cycles -> frameErr 1 pulse, dataOut keeps previous word, busy high until line returns to 1, no retrigger.
REQ-030 CLKS_PER_BIT=8, 2-cycle 0 glitch on idle line -> START rejects, back to IDLE, no valid/frameErr; then a full 8x frame of 0xC3 -> valid with dataOut=0xC3.
REQ-031 rst pulsed low during DATA bit 4 of 0x81 -> all outputs 0 asynchronously, no pulse after release; next full frame 0x7E received correctly.
